// File: rtl/fifo_stream_adapter_if.sv
// Stream adapter bus: FIFO read port plus valid/ready stream.
// slave = adapter side, master = FIFO/consumer side.
interface fifo_stream_adapter_if #(
  parameter int DWIDTH    = 16,
  parameter int BUF_DEPTH = 4
);
  localparam int LW = $clog2(BUF_DEPTH) + 1;

  logic              i_flush;
  logic              o_pop;
  logic              i_fifo_empty;
  logic [DWIDTH-1:0] i_fifo_data;
  logic              i_fifo_vld;
  logic              o_valid;
  logic [DWIDTH-1:0] o_data;
  logic              i_ready;
  logic [LW-1:0]     o_level;
  logic              o_err;

  modport slave (
    input  i_flush,
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_fifo_vld,
    input  i_ready,
    output o_pop,
    output o_valid,
    output o_data,
    output o_level,
    output o_err
  );

  modport master (
    output i_flush,
    output i_fifo_empty,
    output i_fifo_data,
    output i_fifo_vld,
    output i_ready,
    input  o_pop,
    input  o_valid,
    input  o_data,
    input  o_level,
    input  o_err
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
module fifo_stream_adapter #(
  parameter int DWIDTH    = 16,
  parameter int RD_LAT    = 3,
  parameter int BUF_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo_stream_adapter_if.slave bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = LW + 4;

  logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DWIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [RD_LAT-1:0] pend_q, pend_d;
  logic [2:0]        drop_cnt_q, drop_cnt_d;
  logic              err_q, err_d;

  logic [3:0] inflight;
  logic       credit;
  logic       pop;
  logic       drop_act;
  logic       matched;
  logic       full;
  logic       rd_fire;
  logic       wr_try;
  logic       wr_en;
  logic       err_set;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {3'd0, pend_q[i]};
    end
  end

  // Slots are reserved at pop time and freed when
  // the pop bit leaves pend, even if no data came.
  assign credit = (CW'(level_q) + CW'(inflight))
                < CW'(BUF_DEPTH);
  assign pop = rst_n & ~bus.i_flush
             & ~bus.i_fifo_empty & credit;

  assign drop_act = (drop_cnt_q != 3'd0);
  assign matched  = |pend_q;
  assign full     = (level_q == LW'(BUF_DEPTH));
  assign rd_fire  = (level_q != '0) & bus.i_ready;
  assign wr_try   = bus.i_fifo_vld & ~drop_act;
  assign wr_en    = wr_try & matched
                  & (~full | rd_fire);
  assign err_set  = wr_try
                  & (~matched | (full & ~rd_fire));

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pend_d     = (pend_q << 1) | RD_LAT'(pop);
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q | err_set;

    if (drop_act) begin
      drop_cnt_d = drop_cnt_q - 3'd1;
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.i_fifo_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, rd_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Flush overrides every update above.
    if (bus.i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pend_d     = '0;
      drop_cnt_d = 3'(RD_LAT);
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_pop   = pop;
  assign bus.o_valid = (level_q != '0);
  assign bus.o_data  = mem_q[rd_ptr_q];
  assign bus.o_level = level_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: vector table,
// directed sequences and random traffic vs a queue model.
module tb_fifo_stream_adapter;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;

  fifo_stream_adapter_if #(
    .DWIDTH(16), .BUF_DEPTH(DEPTH)
  ) bus ();

  fifo_stream_adapter #(
    .DWIDTH(16), .RD_LAT(RD_LAT), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic fl, rd, em, vl;
    logic [15:0] d;
    logic ep, ev, ee;
    logic [2:0] el;
    logic [15:0] ed;
  } vec_t;

  typedef struct {
    int t;
    logic [15:0] d;
  } arr_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] mb[$];
  logic [15:0] fq[$];
  logic [15:0] got[$];
  int          popq[$];
  arr_t        aq[$];
  logic        merr;
  int          drop_end;
  logic        ign_next;
  logic        inj;
  int          first_pop;
  int          first_vld;
  int          npop;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr_model();
    mb.delete();
    fq.delete();
    got.delete();
    popq.delete();
    aq.delete();
    merr     = 1'b0;
    drop_end = -100;
    ign_next = 1'b0;
    inj      = 1'b0;
  endtask

  task automatic reset_cycle();
    rst_n            = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_ready      = 1'b0;
    bus.i_fifo_empty = 1'b0;
    bus.i_fifo_vld   = 1'b1;
    bus.i_fifo_data  = 16'hFFFF;
    #4;
    chk("rst_pop", bus.o_pop, 0);
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_vld   = 1'b0;
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_pop2", bus.o_pop, 0);
    clr_model();
    cyc++;
  endtask

  // One clock of FIFO + consumer + reference model.
  task automatic step(input logic fl, input logic rd);
    int infl;
    logic vld, ep, rdd, drop, wr;
    logic [15:0] d;
    arr_t a;
    bus.i_flush      = fl;
    bus.i_ready      = rd;
    bus.i_fifo_empty = (fq.size() == 0);
    vld = 1'b0;
    d   = 16'($urandom);
    if (inj) begin
      vld = 1'b1;
      d   = 16'hDEAD;
      inj = 1'b0;
    end else if (aq.size() != 0 && aq[0].t == cyc) begin
      vld = 1'b1;
      d   = aq[0].d;
      aq.delete(0);
    end
    bus.i_fifo_vld  = vld;
    bus.i_fifo_data = d;
    #4;
    infl = 0;
    foreach (popq[i]) begin
      if (cyc - popq[i] >= 1 && cyc - popq[i] <= RD_LAT)
        infl++;
    end
    ep = !fl && fq.size() != 0
       && (mb.size() + infl < DEPTH);
    drop = (cyc <= drop_end);
    chk("pop", bus.o_pop, ep);
    chk("valid", bus.o_valid, mb.size() != 0);
    chk("level", bus.o_level, mb.size());
    chk("err", bus.o_err, merr);
    if (mb.size() != 0) chk("data", bus.o_data, mb[0]);
    if (ep && first_pop < 0) first_pop = cyc;
    if (bus.o_valid && first_vld < 0) first_vld = cyc;
    npop += int'(bus.o_pop);
    if (bus.o_valid && rd && !fl) got.push_back(bus.o_data);
    if (fl) begin
      mb.delete();
      popq.delete();
      fq.delete();
      merr     = 1'b0;
      drop_end = cyc + RD_LAT;
    end else begin
      rdd = (mb.size() != 0) && rd;
      wr  = 1'b0;
      if (vld && !drop) begin
        if (infl == 0) merr = 1'b1;
        else if (mb.size() == DEPTH && !rdd) merr = 1'b1;
        else wr = 1'b1;
      end
      if (rdd) mb.delete(0);
      if (wr) mb.push_back(d);
      if (ep) begin
        popq.push_back(cyc);
        if (ign_next) begin
          ign_next = 1'b0;
        end else begin
          a.t = cyc + RD_LAT;
          a.d = fq[0];
          aq.push_back(a);
          fq.delete(0);
        end
      end
    end
    while (popq.size() != 0 && popq[0] + RD_LAT <= cyc)
      popq.delete(0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_got(input string nm,
                         input int n,
                         input logic [15:0] base);
    chk({nm, "_cnt"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk(nm, got[i], base + 16'(i));
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{0,0,1,0,16'h0000, 0,0,0,3'd0,16'h0000};
    tbl[1]  = '{0,0,0,0,16'h0000, 1,0,0,3'd0,16'h0000};
    tbl[2]  = '{0,0,1,0,16'h0000, 0,0,0,3'd0,16'h0000};
    tbl[3]  = '{0,0,1,0,16'h0000, 0,0,0,3'd0,16'h0000};
    tbl[4]  = '{0,0,1,1,16'hAAAA, 0,0,0,3'd0,16'h0000};
    tbl[5]  = '{0,0,1,0,16'h0000, 0,1,0,3'd1,16'hAAAA};
    tbl[6]  = '{0,1,1,0,16'h0000, 0,1,0,3'd1,16'hAAAA};
    tbl[7]  = '{0,1,1,0,16'h0000, 0,0,0,3'd0,16'h0000};
    tbl[8]  = '{0,1,1,1,16'hBEEF, 0,0,0,3'd0,16'h0000};
    tbl[9]  = '{0,1,1,0,16'h0000, 0,0,1,3'd0,16'h0000};
    tbl[10] = '{1,1,0,0,16'h0000, 0,0,1,3'd0,16'h0000};
    tbl[11] = '{0,1,0,1,16'h1234, 1,0,0,3'd0,16'h0000};
    tbl[12] = '{0,1,1,0,16'h0000, 0,0,0,3'd0,16'h0000};

    rst_n            = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_ready      = 1'b0;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_vld   = 1'b0;
    bus.i_fifo_data  = '0;
    clr_model();
    @(posedge clk);
    #1;
    reset_cycle();

    foreach (tbl[i]) begin
      bus.i_flush      = tbl[i].fl;
      bus.i_ready      = tbl[i].rd;
      bus.i_fifo_empty = tbl[i].em;
      bus.i_fifo_vld   = tbl[i].vl;
      bus.i_fifo_data  = tbl[i].d;
      #4;
      chk($sformatf("tbl%0d_pop", i), bus.o_pop, tbl[i].ep);
      chk($sformatf("tbl%0d_vld", i), bus.o_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_lvl", i), bus.o_level, tbl[i].el);
      chk($sformatf("tbl%0d_err", i), bus.o_err, tbl[i].ee);
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_dat", i), bus.o_data, tbl[i].ed);
      @(posedge clk);
      #1;
    end

    // Fill and stream.
    reset_cycle();
    for (int i = 1; i <= 10; i++) fq.push_back(16'(i));
    first_pop = -1;
    first_vld = -1;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("t1_lat", first_vld - first_pop, RD_LAT + 1);
    chk_got("t1_word", 10, 16'h0001);
    chk("t1_err", bus.o_err, 0);

    // Backpressure.
    reset_cycle();
    for (int i = 0; i < 8; i++) fq.push_back(16'h0100 + 16'(i));
    npop = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("t2_pops", npop, DEPTH);
    #1;
    chk("t2_lvl", bus.o_level, DEPTH);
    chk("t2_pop_hold", bus.o_pop, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1);
    chk_got("t2_word", 8, 16'h0100);

    // Empty gating.
    reset_cycle();
    fq.push_back(16'h0042);
    npop = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("t3_pops", npop, 1);
    chk_got("t3_word", 1, 16'h0042);
    #1;
    chk("t3_lvl", bus.o_level, 0);
    chk("t3_vld", bus.o_valid, 0);

    // Flush mid-flight.
    reset_cycle();
    for (int i = 0; i < 10; i++) fq.push_back(16'h0200 + 16'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    #1;
    chk("t4_pre_lvl", bus.o_level, 2);
    step(1'b1, 1'b0);
    #1;
    chk("t4_lvl", bus.o_level, 0);
    chk("t4_vld", bus.o_valid, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    chk("t4_err", bus.o_err, 0);
    chk("t4_none", got.size(), 0);

    // Ignored pop.
    reset_cycle();
    ign_next = 1'b1;
    for (int i = 0; i < 3; i++) fq.push_back(16'h0300 + 16'(i));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk_got("t5_word", 3, 16'h0300);
    chk("t5_err", bus.o_err, 0);

    // Error is sticky until reset.
    reset_cycle();
    inj = 1'b1;
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("t6_err", bus.o_err, 1);
    reset_cycle();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 32)
        fq.push_back(16'($urandom));
      if ($urandom_range(0, 15) == 0) ign_next = 1'b1;
      step($urandom_range(0, 60) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
